wb_arbiter: RTL and testbench

Writeback arbiter that drives the single register-file write port (`write_reg`/`write_data`/`write_enable`) from two producers. The ALU is single-cycle and cannot be stalled; the load/memory unit uses a valid/ready handshake. Memory results that lose arbitration are held in a small in-order buffer. The block exports a pending-write mask so the hazard logic can stall readers of registers whose load data has not yet been written.

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 87 ++++++++
 tb/tb_wb_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback arbiter bus bundling the ALU/memory producers, the register-file write port and the pending mask
//   alu_valid/alu_rd/alu_data   : single-cycle ALU result, no backpressure
//   mem_valid/mem_ready         : memory result handshake
//   mem_rd/mem_data             : memory result destination and value
//   rf_write_enable/reg/data    : registered register-file write port
//   pending_mask                : registers with a live buffered load result
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, rf_write_enable, rf_write_reg, rf_write_data, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, rf_write_enable, rf_write_reg, rf_write_data, pending_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates one register-file write port between a non-stallable ALU and a buffered memory unit
//   clk   : clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : wb_arbiter_if.slave (ALU/memory inputs, mem_ready, rf write port, pending_mask)
//   DEPTH : memory-result buffer entries, power of two >= 2
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      dat_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdat_q, wdat_d;
    logic             alu_claim, mem_acc, pop, bypass, push, push_vld;
    logic [31:0]      pm;

    assign alu_claim = bus.alu_valid && bus.alu_rd != 5'd0;
    // Ready looks only at the registered count so a same-cycle pop cannot raise it.
    assign bus.mem_ready = (cnt_q != CW'(DEPTH)) && reset;
    assign mem_acc   = bus.mem_valid && bus.mem_ready && bus.mem_rd != 5'd0;
    assign pop       = !alu_claim && cnt_q != '0;
    assign bypass    = mem_acc && !alu_claim && cnt_q == '0;
    assign push      = mem_acc && !bypass;
    // The ALU result is newer, so a same-cycle load to the same register is dead on arrival.
    assign push_vld  = !(alu_claim && bus.mem_rd == bus.alu_rd);
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++)
            if (alu_claim && rd_q[i] == bus.alu_rd) vld_d[i] = 1'b0;
        if (pop) vld_d[rp_q] = 1'b0;
        if (push) vld_d[wp_q] = push_vld;
        // Popping a squashed head still consumes the slot but writes nothing.
        we_d   = alu_claim || (pop && vld_q[rp_q]) || bypass;
        wreg_d = alu_claim ? bus.alu_rd : pop ? rd_q[rp_q] : bus.mem_rd;
        wdat_d = alu_claim ? bus.alu_data : pop ? dat_q[rp_q] : bus.mem_data;
    end

    always_comb begin
        pm = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i]) pm[rd_q[i]] = 1'b1;
        pm[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            vld_q  <= '0;
            we_q   <= 1'b0;
            wreg_q <= '0;
            wdat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            we_q  <= we_d;
            if (we_d) begin
                wreg_q <= wreg_d;
                wdat_q <= wdat_d;
            end
            if (push) begin
                rd_q[wp_q]  <= bus.mem_rd;
                dat_q[wp_q] <= bus.mem_data;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
        end
    end

    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_reg    = wreg_q;
    assign bus.rf_write_data   = wdat_q;
    assign bus.pending_mask    = pm;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with directed scenarios and randomized traffic
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    logic inited = 1'b0;
    logic prev_rst = 1'b1;
    wr_t  expq[$];
    ent_t buf_m[$];

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then advance the reference model
    // to what the next posedge must do.
    task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md, output logic acc);
        logic        rdy, claim, take;
        logic [31:0] mask;
        ent_t        e;
        @(negedge clk);
        reset = rst;
        bus.alu_valid = av;
        bus.alu_rd = ard;
        bus.alu_data = ad;
        bus.mem_valid = mv;
        bus.mem_rd = mrd;
        bus.mem_data = md;
        #1;
        if (!prev_rst) begin
            chk("reset_we", {31'd0, bus.rf_write_enable}, 32'd0);
            chk("reset_reg", {27'd0, bus.rf_write_reg}, 32'd0);
            chk("reset_data", bus.rf_write_data, 32'd0);
        end
        rdy = rst && buf_m.size() < DEPTH;
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, rdy});
        if (inited) begin
            mask = 0;
            foreach (buf_m[i]) if (buf_m[i].v) mask[buf_m[i].rd] = 1'b1;
            chk("pending_mask", bus.pending_mask, mask);
        end
        acc = mv && rdy;
        if (!rst) begin
            buf_m.delete();
            inited = 1'b1;
        end else begin
            claim = av && ard != 0;
            take = acc && mrd != 0;
            if (claim) begin
                expq.push_back('{cyc + 1, ard, ad});
                foreach (buf_m[i]) if (buf_m[i].rd == ard) buf_m[i].v = 1'b0;
            end else if (buf_m.size() > 0) begin
                e = buf_m.pop_front();
                if (e.v) expq.push_back('{cyc + 1, e.rd, e.d});
            end else if (take) begin
                expq.push_back('{cyc + 1, mrd, md});
                take = 1'b0;
            end
            if (take) buf_m.push_back('{!(claim && mrd == ard), mrd, md});
        end
        prev_rst = rst;
    endtask

    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (inited && bus.rf_write_enable) begin
                if (expq.size() == 0) begin
                    chk("spurious_write", {27'd0, bus.rf_write_reg}, 32'd0);
                end else begin
                    w = expq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_reg", {27'd0, bus.rf_write_reg}, {27'd0, w.rd});
                    chk("write_data", bus.rf_write_data, w.d);
                end
            end
        end
    end

    initial begin
        logic        a, off_v;
        logic [4:0]  off_rd;
        logic [31:0] off_d;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
        // Reset then idle
        step(0, 0, 0, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, 0, a);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, a);
        // Memory bypass
        step(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, a);
        step(1, 0, 0, 0, 0, 0, 0, a);
        // Conflict and buffering
        step(1, 1, 3, 32'h11, 1, 7, 32'h22, a);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, a);
        // Full backpressure
        step(1, 1, 1, 32'h101, 1, 8, 32'h88, a);
        step(1, 1, 1, 32'h102, 1, 9, 32'h99, a);
        step(1, 1, 1, 32'h103, 1, 10, 32'hAA0, a);
        step(1, 0, 0, 0, 1, 10, 32'hAA0, a);
        step(1, 0, 0, 0, 1, 10, 32'hAA0, a);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, a);
        // Squash
        step(1, 1, 1, 32'h1, 1, 4, 32'hAA, a);
        step(1, 1, 4, 32'hBB, 0, 0, 0, a);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, a);
        // Same-cycle squash of an incoming load
        step(1, 1, 6, 32'h66, 1, 6, 32'h77, a);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, a);
        // rd=0 from both producers
        step(1, 0, 0, 0, 1, 0, 32'h55, a);
        step(1, 1, 0, 32'h44, 0, 0, 0, a);
        step(1, 0, 0, 0, 0, 0, 0, a);
        // Reset mid-operation with two entries buffered
        step(1, 1, 2, 32'h2, 1, 11, 32'hB1, a);
        step(1, 1, 2, 32'h3, 1, 12, 32'hC1, a);
        step(0, 1, 2, 32'h4, 1, 13, 32'hD1, a);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, a);
        // Randomized traffic; a memory offer is held until accepted
        off_v = 0; off_rd = 0; off_d = 0;
        for (int n = 0; n < 3000; n++) begin
            logic rst;
            if (!off_v && $urandom_range(1, 0) == 1) begin
                off_v = 1;
                off_rd = 5'($urandom_range(7, 0));
                off_d = $urandom;
            end
            rst = $urandom_range(99, 0) != 0;
            step(rst, 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
                 off_v, off_rd, off_d, a);
            if (a || !rst) off_v = 0;
        end
        repeat (DEPTH + 3) step(1, 0, 0, 0, 0, 0, 0, a);
        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
